spi_config_port: RTL and testbench

- Upstream front-end that drives the configuration shift-register chain (clock-divider config plus symmetric-coefficient flag, 5 bits total) from external SPI-style pins.
- Synchronises sck, csN and mosi into the clk domain and detects sck edges.
- Converts each sck rising edge inside a frame into a one-cycle serialEn/serialIn shift, and returns the chain's serialOut on miso for readback.
- Reports frame completion and whether exactly the expected number of bits arrived.

---
 rtl/spi_config_pkg.sv | 13 +
 rtl/spi_config_port_bit_sync.sv | 27 ++
 rtl/spi_config_port.sv | 113 +++++++++++
 tb/tb_spi_config_port.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_config_pkg.sv
// Shared types and defaults for the SPI configuration port.
// Holds the frame FSM state encoding and the default synchroniser depth.
package spi_config_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DefSyncStages = 2;

endpackage

// File: rtl/spi_config_port_bit_sync.sv
// N-flop synchroniser bringing one asynchronous pin into the clk domain.
// Ports: clk, resetN (sync, active-low), d (async pin), q (synced value).
module bit_sync
  import spi_config_pkg::*;
#(
  parameter int   N        = DefSyncStages,
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      ff <= {N{ResetVal}};
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/spi_config_port.sv
// SPI-style front end that shifts a frame into the config chain and reads it back.
// Ports: clk, resetN, sckIn/csNIn/mosiIn (async pins), misoOut/misoOe,
//        serialEn/serialIn/serialOut (chain), frameDone/frameOk/bitCount.
module spi_config_port
  import spi_config_pkg::*;
#(
  parameter int SyncStages  = DefSyncStages,
  parameter int CountWidth  = 8,
  parameter int ChainLength = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sckIn,
  input  logic                  csNIn,
  input  logic                  mosiIn,
  output logic                  misoOut,
  output logic                  misoOe,
  output logic                  serialEn,
  output logic                  serialIn,
  input  logic                  serialOut,
  output logic                  frameDone,
  output logic                  frameOk,
  output logic [CountWidth-1:0] bitCount
);

  localparam int WarmCycles = SyncStages + 1;
  localparam int WarmW      = $clog2(WarmCycles + 1);

  logic sckS, csNS, mosiS;
  logic sckQ, csNQ;
  logic [WarmW-1:0] warm;
  logic warmDone;
  logic sckRise, sckFall, csFall, csRise;
  state_t state;

  bit_sync #(.N(SyncStages), .ResetVal(1'b0)) uSck (
    .clk(clk), .resetN(resetN), .d(sckIn), .q(sckS)
  );
  bit_sync #(.N(SyncStages), .ResetVal(1'b1)) uCsN (
    .clk(clk), .resetN(resetN), .d(csNIn), .q(csNS)
  );
  bit_sync #(.N(SyncStages), .ResetVal(1'b0)) uMosi (
    .clk(clk), .resetN(resetN), .d(mosiIn), .q(mosiS)
  );

  // After reset the synchronisers still hold reset values; edges seen
  // while the real pin levels flush through would be false (e.g. csN
  // held low across a reset), so edge detection waits until flushed.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sckQ <= 1'b0;
      csNQ <= 1'b1;
      warm <= '0;
    end else begin
      sckQ <= sckS;
      csNQ <= csNS;
      if (!warmDone) warm <= warm + 1'b1;
    end
  end

  assign warmDone = (warm == WarmW'(WarmCycles));
  assign sckRise  = warmDone &  sckS & ~sckQ;
  assign sckFall  = warmDone & ~sckS &  sckQ;
  assign csFall   = warmDone & ~csNS &  csNQ;
  assign csRise   = warmDone &  csNS & ~csNQ;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      misoOut   <= 1'b0;
      misoOe    <= 1'b0;
      serialEn  <= 1'b0;
      serialIn  <= 1'b0;
      frameDone <= 1'b0;
      frameOk   <= 1'b0;
      bitCount  <= '0;
    end else begin
      serialEn <= 1'b0;
      unique case (state)
        IDLE: begin
          if (csFall) begin
            state    <= ACTIVE;
            misoOe   <= 1'b1;
            bitCount <= '0;
            misoOut  <= serialOut;
          end
        end
        ACTIVE: begin
          // csN rise takes priority: a coincident sck edge is dropped.
          if (csRise) begin
            state     <= DONE;
            misoOe    <= 1'b0;
            frameDone <= 1'b1;
            frameOk   <= (bitCount == CountWidth'(ChainLength));
          end else if (sckRise) begin
            serialEn <= 1'b1;
            serialIn <= mosiS;
            if (bitCount != '1) bitCount <= bitCount + 1'b1;
          end else if (sckFall) begin
            misoOut <= serialOut;
          end
        end
        DONE: begin
          state     <= IDLE;
          frameDone <= 1'b0;
          frameOk   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_port.sv
// Directed testbench for spi_config_port with a 5-bit chain model.
// Drives pins on negedge clk and samples outputs 1 unit after posedge.
module tb_spi_config_port;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sckIn, csNIn, mosiIn;
  logic       misoOut, misoOe;
  logic       serialEn, serialIn, serialOut;
  logic       frameDone, frameOk;
  logic [7:0] bitCount;

  int total = 0;
  int bad   = 0;

  logic [4:0]  chain = 5'b0;
  logic        loadReq = 1'b0;
  logic [4:0]  loadVal = 5'b0;

  int          cyc = 0;
  int          enCount = 0;
  logic [31:0] enVec = '0;
  int          enCyc[$];
  int          riseCyc[$];
  int          doneCount = 0;
  logic        lastOk = 1'b0;
  logic [7:0]  lastCnt = '0;
  logic        oeAtDone = 1'b0;
  logic [31:0] misoVec = '0;
  int          oeLowAtRise = 0;

  always #5 clk = ~clk;

  spi_config_port dut (
    .clk(clk), .resetN(resetN),
    .sckIn(sckIn), .csNIn(csNIn), .mosiIn(mosiIn),
    .misoOut(misoOut), .misoOe(misoOe),
    .serialEn(serialEn), .serialIn(serialIn), .serialOut(serialOut),
    .frameDone(frameDone), .frameOk(frameOk), .bitCount(bitCount)
  );

  assign serialOut = chain[4];

  // Config chain model: shifts one cycle after serialEn.
  always @(posedge clk) begin
    if (loadReq) chain <= loadVal;
    else if (serialEn) chain <= {chain[3:0], serialIn};
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (serialEn === 1'b1) begin
      enCount = enCount + 1;
      enVec = {enVec[30:0], serialIn};
      enCyc.push_back(cyc);
    end
    if (frameDone === 1'b1) begin
      doneCount = doneCount + 1;
      lastOk = frameOk;
      lastCnt = bitCount;
      oeAtDone = misoOe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMon();
    enCount = 0;
    enVec = '0;
    enCyc.delete();
    riseCyc.delete();
    doneCount = 0;
    misoVec = '0;
    oeLowAtRise = 0;
  endtask

  task automatic preload(input logic [4:0] v);
    loadVal = v;
    loadReq = 1'b1;
    tick(1);
    loadReq = 1'b0;
  endtask

  task automatic sendFrame(input int nbits, input logic [31:0] pat);
    csNIn = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      mosiIn = (nbits <= 32) ? pat[nbits-1-i] : 1'b0;
      tick(8);
      misoVec = {misoVec[30:0], misoOut};
      if (misoOe !== 1'b1) oeLowAtRise = oeLowAtRise + 1;
      riseCyc.push_back(cyc);
      sckIn = 1'b1;
      tick(8);
      sckIn = 1'b0;
    end
    tick(8);
    csNIn = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    sckIn = 1'b0; csNIn = 1'b1; mosiIn = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick(1);
    total++;
    if ({misoOut, misoOe, serialEn, serialIn, frameDone, frameOk} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b want=000000",
               {misoOut, misoOe, serialEn, serialIn, frameDone, frameOk});
    end
    total++;
    if (bitCount !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", bitCount);
    end
  endtask

  task automatic test_idle_sck();
    clearMon();
    for (int i = 0; i < 20; i++) begin
      sckIn = ~sckIn;
      tick(8);
    end
    sckIn = 1'b0;
    tick(8);
    total++;
    if (enCount !== 0 || doneCount !== 0) begin
      bad++;
      $display("FAIL idle_sck en=%0d done=%0d want 0/0", enCount, doneCount);
    end
  endtask

  task automatic test_frame5();
    int lat;
    clearMon();
    sendFrame(5, 32'b10110);
    total++;
    if (enCount !== 5) begin
      bad++;
      $display("FAIL f5_pulses got=%0d want=5", enCount);
    end
    total++;
    if (enVec[4:0] !== 5'b10110) begin
      bad++;
      $display("FAIL f5_bits got=%b want=10110", enVec[4:0]);
    end
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < enCyc.size() && i < riseCyc.size())
        if (enCyc[i] - riseCyc[i] != 3) lat++;
    end
    total++;
    if (lat !== 0 || enCyc.size() != 5) begin
      bad++;
      $display("FAIL f5_latency wrong=%0d pulses=%0d want 0/5", lat, enCyc.size());
    end
    total++;
    if (doneCount !== 1 || lastOk !== 1'b1 || lastCnt !== 8'd5) begin
      bad++;
      $display("FAIL f5_done done=%0d ok=%b cnt=%0d want 1/1/5",
               doneCount, lastOk, lastCnt);
    end
    total++;
    if (bitCount !== 8'd5 || frameDone !== 1'b0 || frameOk !== 1'b0) begin
      bad++;
      $display("FAIL f5_after cnt=%0d done=%b ok=%b want 5/0/0",
               bitCount, frameDone, frameOk);
    end
  endtask

  task automatic test_readback();
    clearMon();
    preload(5'b11111);
    sendFrame(5, 32'b0);
    total++;
    if (misoVec[4:0] !== 5'b11111) begin
      bad++;
      $display("FAIL rb_ones got=%b want=11111", misoVec[4:0]);
    end
    total++;
    if (oeLowAtRise !== 0 || oeAtDone !== 1'b0 || misoOe !== 1'b0) begin
      bad++;
      $display("FAIL rb_oe lowInFrame=%0d atDone=%b now=%b want 0/0/0",
               oeLowAtRise, oeAtDone, misoOe);
    end
    clearMon();
    preload(5'b10110);
    sendFrame(5, 32'b0);
    total++;
    if (misoVec[4:0] !== 5'b10110) begin
      bad++;
      $display("FAIL rb_pattern got=%b want=10110", misoVec[4:0]);
    end
    total++;
    if (chain !== 5'b00000) begin
      bad++;
      $display("FAIL rb_chain got=%b want=00000", chain);
    end
  endtask

  task automatic test_short_long();
    clearMon();
    sendFrame(3, 32'b101);
    total++;
    if (doneCount !== 1 || lastOk !== 1'b0 || lastCnt !== 8'd3) begin
      bad++;
      $display("FAIL short done=%0d ok=%b cnt=%0d want 1/0/3",
               doneCount, lastOk, lastCnt);
    end
    clearMon();
    sendFrame(300, 32'b0);
    total++;
    if (doneCount !== 1 || lastOk !== 1'b0 || lastCnt !== 8'd255) begin
      bad++;
      $display("FAIL long done=%0d ok=%b cnt=%0d want 1/0/255",
               doneCount, lastOk, lastCnt);
    end
    total++;
    if (enCount !== 300) begin
      bad++;
      $display("FAIL long_pulses got=%0d want=300", enCount);
    end
  endtask

  task automatic test_cs_collision();
    clearMon();
    csNIn = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      mosiIn = 1'b1;
      tick(8);
      sckIn = 1'b1;
      tick(8);
      sckIn = 1'b0;
    end
    tick(8);
    sckIn = 1'b1;
    csNIn = 1'b1;
    tick(8);
    sckIn = 1'b0;
    tick(10);
    total++;
    if (enCount !== 4) begin
      bad++;
      $display("FAIL coll_pulses got=%0d want=4", enCount);
    end
    total++;
    if (doneCount !== 1 || lastOk !== 1'b0 || lastCnt !== 8'd4) begin
      bad++;
      $display("FAIL coll_done done=%0d ok=%b cnt=%0d want 1/0/4",
               doneCount, lastOk, lastCnt);
    end
  endtask

  task automatic test_reset_mid();
    clearMon();
    csNIn = 1'b0;
    tick(8);
    for (int i = 0; i < 2; i++) begin
      mosiIn = 1'b1;
      tick(8);
      sckIn = 1'b1;
      tick(8);
      sckIn = 1'b0;
    end
    tick(4);
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
    enCount = 0;
    for (int i = 0; i < 3; i++) begin
      tick(8);
      sckIn = 1'b1;
      tick(8);
      sckIn = 1'b0;
    end
    tick(8);
    total++;
    if (enCount !== 0 || doneCount !== 0 || misoOe !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid en=%0d done=%0d oe=%b want 0/0/0",
               enCount, doneCount, misoOe);
    end
    total++;
    if (bitCount !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid_cnt got=%0d want=0", bitCount);
    end
    csNIn = 1'b1;
    tick(10);
    total++;
    if (doneCount !== 0) begin
      bad++;
      $display("FAIL rst_mid_csrise done=%0d want=0", doneCount);
    end
    clearMon();
    sendFrame(5, 32'b01101);
    total++;
    if (doneCount !== 1 || lastOk !== 1'b1 || lastCnt !== 8'd5 ||
        enVec[4:0] !== 5'b01101) begin
      bad++;
      $display("FAIL rst_next done=%0d ok=%b cnt=%0d bits=%b want 1/1/5/01101",
               doneCount, lastOk, lastCnt, enVec[4:0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_sck();
    test_frame5();
    test_readback();
    test_short_long();
    test_cs_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
